// File: rtl/exc_pkg.sv
// Shared definitions for the exception request unit: cause codes, status bit
// positions, trap kind encodings and the sequencer state type.
package exc_pkg;

  localparam logic [4:0] CAUSE_INT     = 5'b00000;
  localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
  localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

  localparam int ST_IE    = 0;
  localparam int ST_SYS   = 1;
  localparam int ST_BRK   = 2;
  localparam int ST_TEQ   = 3;
  localparam int ST_IM_LO = 8;

  localparam logic [1:0] KIND_NONE    = 2'b00;
  localparam logic [1:0] KIND_SYSCALL = 2'b01;
  localparam logic [1:0] KIND_BREAK   = 2'b10;
  localparam logic [1:0] KIND_TEQ     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PENDING,
    S_COMMIT,
    S_REDIRECT,
    S_ERET
  } exc_state_e;

  function automatic logic [4:0] trap_cause(input logic [1:0] kind);
    case (kind)
      KIND_SYSCALL: trap_cause = CAUSE_SYSCALL;
      KIND_BREAK:   trap_cause = CAUSE_BREAK;
      KIND_TEQ:     trap_cause = CAUSE_TEQ;
      default:      trap_cause = CAUSE_INT;
    endcase
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/exc_req_unit.sv
// Exception request unit: gates traps and interrupts with CP0 status, waits for
// the instruction boundary, then drives the CP0 exception / eret handshakes.
//
// state      | meaning
// S_IDLE     | waiting for trap, eret or interrupt
// S_PENDING  | request latched, waiting for instruction boundary
// S_COMMIT   | exception pulse to CP0 with cause/epc
// S_REDIRECT | PC loads from CP0 exception address
// S_ERET     | eret pulse and PC redirect
module exc_req_unit
  import exc_pkg::*;
#(
  parameter int IRQ_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trap_valid,
  input  logic [1:0]       trap_kind,
  input  logic             teq_eq,
  input  logic [31:0]      trap_pc,
  input  logic [31:0]      next_pc,
  input  logic             boundary,
  input  logic             eret_req,
  input  logic [IRQ_W-1:0] irq,
  input  logic [31:0]      status,
  output logic             exception,
  output logic [4:0]       cause,
  output logic [31:0]      epc,
  output logic             eret,
  output logic             pc_redirect,
  output logic             busy
);

  exc_state_e       state_q, state_d;
  logic [IRQ_W-1:0] irq_s;
  logic [4:0]       cause_q;
  logic [31:0]      epc_q;
  logic             is_irq;
  logic             kind_en;
  logic             trap_acc;
  logic             irq_req;
  logic             unused_status;

  sync2 #(.W(IRQ_W)) u_irq_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq),
    .q     (irq_s)
  );

  always_comb begin
    kind_en = 1'b0;
    case (trap_kind)
      KIND_SYSCALL: kind_en = status[ST_SYS];
      KIND_BREAK:   kind_en = status[ST_BRK];
      KIND_TEQ:     kind_en = status[ST_TEQ] & teq_eq;
      default:      kind_en = 1'b0;
    endcase
  end

  assign trap_acc = trap_valid & status[ST_IE] & kind_en;
  assign irq_req  = (|(irq_s & status[ST_IM_LO +: IRQ_W])) & status[ST_IE];
  assign unused_status = ^{status[31:ST_IM_LO+IRQ_W], status[ST_IM_LO-1:ST_TEQ+1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (trap_acc)      state_d = S_PENDING;
        else if (eret_req) state_d = S_ERET;
        else if (irq_req)  state_d = S_PENDING;
      end
      S_PENDING:  if (boundary) state_d = S_COMMIT;
      S_COMMIT:   state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      S_ERET:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    exception   = (state_q == S_COMMIT);
    eret        = (state_q == S_ERET);
    pc_redirect = (state_q == S_REDIRECT) || (state_q == S_ERET);
    busy        = (state_q != S_IDLE);
  end

  // cause/epc outputs load on entry to COMMIT and hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q <= '0;
      epc_q   <= '0;
      is_irq  <= 1'b0;
      cause   <= '0;
      epc     <= '0;
    end else begin
      if (state_q == S_IDLE) begin
        if (trap_acc) begin
          cause_q <= trap_cause(trap_kind);
          epc_q   <= trap_pc;
          is_irq  <= 1'b0;
        end else if (!eret_req && irq_req) begin
          cause_q <= CAUSE_INT;
          is_irq  <= 1'b1;
        end
      end
      if (state_q == S_PENDING && boundary) begin
        cause <= cause_q;
        epc   <= is_irq ? next_pc : epc_q;
      end
    end
  end

endmodule

// File: doc/exc_req_unit.md
# exc_req_unit

Exception request unit for the multi-cycle CPU: the initiating side of the CP0 exception interface. Collects synchronous trap requests from instruction decode (syscall, break, teq) and asynchronous external interrupts, gates them with the CP0 status word, and waits for the main controller's instruction boundary. It then drives the one-cycle `exception` / `cause` / EPC handshake into CP0 and the matching PC redirect. It also sequences `eret` into CP0 and the PC path.

## Interface
- `IRQ_W`, 4: number of external interrupt lines.
- `clk`  in  1  system clock, all flops rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `trap_valid`  in  1  decode strobe, one cycle, instruction is a trap candidate.
- `trap_kind`  in  2  01 syscall, 10 break, 11 teq; 00 ignored.
- `teq_eq`  in  1  rs==rt for teq; teq traps only when 1.
- `trap_pc`  in  32  PC of the decoded instruction.
- `next_pc`  in  32  PC of the next instruction, used as EPC for interrupts.
- `boundary`  in  1  controller is at instruction end; exception may be taken.
- `eret_req`  in  1  decode strobe for eret, one cycle.
- `irq`  in  IRQ_W  asynchronous level interrupt lines.
- `status`  in  32  CP0 status word.
- `exception`  out  1  one-cycle pulse to CP0.
- `cause`  out  5  cause code to CP0, valid with `exception`.
- `epc`  out  32  PC to CP0, valid with `exception`.
- `eret`  out  1  one-cycle pulse to CP0 and the PC mux.
- `pc_redirect`  out  1  one-cycle pulse; controller loads PC from CP0 `exc_addr`.
- `busy`  out  1  unit not idle; controller stalls decode of new traps/eret.

## Operation
- Status bits: [0] IE global enable; [1] syscall enable; [2] break enable; [3] teq enable; [11:8] per-line irq mask. CP0 shifts status left by 5 on exception, so IE clears automatically.
- Cause codes: syscall 5'b01000, break 5'b01001, teq 5'b01101, interrupt 5'b00000.
- `irq` passes through a 2-flop synchronizer. The interrupt request is `|(irq_s & status[11:8]) & status[0]`.
- Trap accepted when: `trap_valid`, IE set, kind enable bit set and, for teq, `teq_eq`=1. Disabled or non-matching traps are dropped silently.
- FSM states: IDLE, PENDING, COMMIT, REDIRECT, ERET.
- IDLE transitions, in priority order:
  - accepted trap -> PENDING; latch cause and `trap_pc`.
  - `eret_req` -> ERET.
  - interrupt request -> PENDING; latch cause 0; set `is_irq`.
- PENDING: on `boundary`=1 -> COMMIT. For interrupts, latch `next_pc` into EPC at this edge.
- COMMIT: `exception`=1, `cause`/`epc` driven from latches -> REDIRECT.
- REDIRECT: `pc_redirect`=1 -> IDLE.
- ERET: `eret`=1 and `pc_redirect`=1 -> IDLE.
- `busy`=1 in every state except IDLE. Inputs `trap_valid`/`eret_req` are ignored while busy.
- Simultaneous trap and interrupt in IDLE: the trap wins. The interrupt remains level-pending and is taken after return, once IE is set again.
- Simultaneous trap and `eret_req`: the trap wins and eret is dropped; the controller never issues both.
- Interrupt deasserted while PENDING: the exception is still taken with cause 0. The request is not withdrawn.

## Timing
- Reset: state IDLE; all outputs 0; `cause`=0; `epc`=0; cause/EPC latches and synchronizer flops cleared. Reset asserted mid-sequence aborts to IDLE with no further pulses.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Trap strobe at cycle t -> `busy` at t+1. If `boundary` is first seen at cycle b (≥ t+1), then `exception` is high at b+1, `pc_redirect` at b+2, and `busy` low at b+3.
- `boundary` is sampled only in PENDING; a `boundary` coinciding with the strobe does not count.
- `irq` edge at t -> earliest PENDING at t+3, including synchronizer latency.
- `eret_req` at t -> `eret` and `pc_redirect` at t+1; `busy` low at t+2.
- `cause` and `epc` hold their values after COMMIT until the next COMMIT.

## Structure
- Package `exc_pkg`: cause code constants, status bit indices, `trap_kind` encodings, FSM state enum.
- Sub-module `sync2`: parameterized-width 2-flop synchronizer with async active-low reset, instantiated for `irq`.

## Test plan
- Syscall: status=0x3, `trap_kind`=01, `trap_pc`=0x100, `boundary` 2 cycles later -> `exception` pulse, cause 0x08, epc 0x100; then `pc_redirect`; then idle.
- teq with `teq_eq`=0 -> no response. With `teq_eq`=1 and status=0x9 -> cause 0x0D.
- Break with status=0x1 (bit 2 clear) -> dropped; `busy` stays 0.
- irq[2] raised, status=0x401, `next_pc`=0x200 at boundary -> cause 0, epc 0x200. With status=0x400 (IE=0) -> no exception.
- Syscall and irq in the same cycle, status=0x403 -> syscall taken first; irq taken after status is restored to 0x403.
- `eret_req` -> `eret`+`pc_redirect` next cycle. Then `rst_n` pulled low while PENDING -> all outputs 0, no `exception` after release.
